// File: rtl/w_grf_if.sv
// W-stage pipeline register contents, D-stage read ports and writeback trace bundle.
// master drives W/D inputs (pipeline side), slave is the register-file block.
interface w_grf_if;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [31:0] w_alu_out;
  logic [31:0] w_dm_out;
  logic [31:0] w_ext;
  logic [4:0]  d_rs_addr;
  logic [4:0]  d_rt_addr;
  logic [31:0] d_rs_data;
  logic [31:0] d_rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] retired;

  modport master (
    output w_pc, w_instr, w_alu_out, w_dm_out, w_ext, d_rs_addr, d_rt_addr,
    input  d_rs_data, d_rt_data, wb_en, wb_addr, wb_data, wb_pc, retired
  );

  modport slave (
    input  w_pc, w_instr, w_alu_out, w_dm_out, w_ext, d_rs_addr, d_rt_addr,
    output d_rs_data, d_rt_data, wb_en, wb_addr, wb_data, wb_pc, retired
  );
endinterface

// File: rtl/w_grf.sv
// Writeback stage: decodes the W instruction, writes the 32x32 register file and
// serves the two D-stage read ports with same-cycle bypass; counts retired instructions.
module w_grf #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input logic    clk,
  input logic    reset,
  w_grf_if.slave bus
);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("RESET_PC must be word aligned");
  end

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        dec_we;
  logic [4:0]  dec_dest;
  logic [31:0] dec_data;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] retired_q;
  logic [31:0] retired_d;

  assign opcode = bus.w_instr[31:26];
  assign funct  = bus.w_instr[5:0];
  assign rt     = bus.w_instr[20:16];
  assign rd     = bus.w_instr[15:11];

  always_comb begin
    dec_we   = 1'b0;
    dec_dest = 5'd0;
    dec_data = 32'd0;
    case (opcode)
      6'h00: begin
        if (funct inside {6'h20, 6'h21, 6'h22, 6'h23}) begin
          dec_we   = 1'b1;
          dec_dest = rd;
          dec_data = bus.w_alu_out;
        end
      end
      6'h0d: begin
        dec_we   = 1'b1;
        dec_dest = rt;
        dec_data = bus.w_alu_out;
      end
      6'h23: begin
        dec_we   = 1'b1;
        dec_dest = rt;
        dec_data = bus.w_dm_out;
      end
      6'h0f: begin
        dec_we   = 1'b1;
        dec_dest = rt;
        dec_data = bus.w_ext;
      end
      6'h03: begin
        dec_we   = 1'b1;
        dec_dest = 5'd31;
        dec_data = bus.w_pc + LINK_OFFSET;
      end
      default: ;
    endcase
  end

  // Writes to $0 are squashed so the trace shows no write at all.
  assign bus.wb_en   = dec_we && (dec_dest != 5'd0);
  assign bus.wb_addr = bus.wb_en ? dec_dest : 5'd0;
  assign bus.wb_data = bus.wb_en ? dec_data : 32'd0;
  assign bus.wb_pc   = bus.w_pc;
  assign bus.retired = retired_q;

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en) begin
      regs_d[bus.wb_addr] = bus.wb_data;
    end
  end

  assign retired_d = retired_q + {31'd0, (bus.w_instr != 32'd0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      retired_q <= 32'd0;
    end else begin
      regs_q    <= regs_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    bus.d_rs_data = regs_q[bus.d_rs_addr];
    if (bus.d_rs_addr == 5'd0) begin
      bus.d_rs_data = 32'd0;
    end else if (bus.wb_en && (bus.wb_addr == bus.d_rs_addr)) begin
      bus.d_rs_data = bus.wb_data;
    end
  end

  always_comb begin
    bus.d_rt_data = regs_q[bus.d_rt_addr];
    if (bus.d_rt_addr == 5'd0) begin
      bus.d_rt_data = 32'd0;
    end else if (bus.wb_en && (bus.wb_addr == bus.d_rt_addr)) begin
      bus.d_rt_data = bus.wb_data;
    end
  end

endmodule

// File: tb/tb_w_grf.sv
// Directed bench for w_grf: expectations are queued when a step is driven and
// popped in order as each DUT output is sampled.
module tb_w_grf;

  logic clk;
  logic reset;

  w_grf_if bus ();

  w_grf #(
    .RESET_PC    (32'h0000_3000),
    .LINK_OFFSET (32'd8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_fail;

  task automatic want(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h, want nothing queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: got %h, want %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] ext, input logic [4:0] ra,
                       input logic [4:0] rb);
    bus.w_pc      = pc;
    bus.w_instr   = instr;
    bus.w_alu_out = alu;
    bus.w_dm_out  = dm;
    bus.w_ext     = ext;
    bus.d_rs_addr = ra;
    bus.d_rt_addr = rb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);

    // 1: reset state
    #1;
    want("rst_rs5", 32'h0);     got(bus.d_rs_data);
    want("rst_rt31", 32'h0);    got(bus.d_rt_data);
    want("rst_retired", 32'h0); got(bus.retired);
    step();
    step();
    reset = 1'b0;

    // 2: ori $8,$0,0x1234 with bypass on port A
    drive(32'h3004, 32'h3408_1234, 32'h1234, 32'h0, 32'h0, 5'd8, 5'd0);
    #1;
    want("ori_wb_en", 32'h1);      got({31'd0, bus.wb_en});
    want("ori_wb_addr", 32'd8);    got({27'd0, bus.wb_addr});
    want("ori_wb_data", 32'h1234); got(bus.wb_data);
    want("ori_bypass", 32'h1234);  got(bus.d_rs_data);
    want("ori_rt0", 32'h0);        got(bus.d_rt_data);
    want("ori_wb_pc", 32'h3004);   got(bus.wb_pc);
    step();
    drive(32'h3008, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
    #1;
    want("ori_reg8", 32'h1234);   got(bus.d_rs_data);
    want("bubble_wb_en", 32'h0);  got({31'd0, bus.wb_en});
    want("bubble_addr", 32'h0);   got({27'd0, bus.wb_addr});
    want("bubble_data", 32'h0);   got(bus.wb_data);
    want("ori_retired", 32'd1);   got(bus.retired);
    step();

    // 3: jal links w_pc + 8 into $31
    drive(32'h3010, 32'h0C00_0C00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd31);
    #1;
    want("jal_wb_addr", 32'd31);    got({27'd0, bus.wb_addr});
    want("jal_wb_data", 32'h3018);  got(bus.wb_data);
    want("jal_bypass31", 32'h3018); got(bus.d_rt_data);
    step();
    drive(32'h3014, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
    #1;
    want("jal_reg31", 32'h3018); got(bus.d_rt_data);
    want("jal_retired", 32'd2);  got(bus.retired);
    step();

    // 4: addu $0 is dropped
    drive(32'h3018, 32'h0000_0021, 32'hDEAD, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    want("r0_wb_en", 32'h0);   got({31'd0, bus.wb_en});
    want("r0_wb_data", 32'h0); got(bus.wb_data);
    want("r0_read", 32'h0);    got(bus.d_rs_data);
    step();
    drive(32'h301c, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8);
    #1;
    want("r0_read_after", 32'h0); got(bus.d_rs_data);
    want("r0_retired", 32'd3);    got(bus.retired);
    step();

    // 5: sw, beq, then three bubbles
    drive(32'h3020, 32'hAC08_0000, 32'h8, 32'h0, 32'h0, 5'd8, 5'd31);
    #1;
    want("sw_wb_en", 32'h0); got({31'd0, bus.wb_en});
    step();
    drive(32'h3024, 32'h1000_0003, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
    #1;
    want("beq_wb_en", 32'h0); got({31'd0, bus.wb_en});
    step();
    drive(32'h3028, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
    #1;
    want("swbeq_retired", 32'd5); got(bus.retired);
    want("swbeq_reg8", 32'h1234); got(bus.d_rs_data);
    want("swbeq_reg31", 32'h3018); got(bus.d_rt_data);
    step();
    step();
    step();
    want("bubbles_retired", 32'd5); got(bus.retired);

    // subu $5 with both ports hitting the bypass
    drive(32'h302c, 32'h0000_2823, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd5, 5'd5);
    #1;
    want("subu_rs_bypass", 32'hA5A5_A5A5); got(bus.d_rs_data);
    want("subu_rt_bypass", 32'hA5A5_A5A5); got(bus.d_rt_data);
    step();

    // lui $10 takes the extended immediate; $5 now from the array
    drive(32'h3030, 32'h3C0A_BEEF, 32'h1111, 32'h2222, 32'hBEEF_0000, 5'd5, 5'd10);
    #1;
    want("lui_wb_data", 32'hBEEF_0000); got(bus.wb_data);
    want("subu_reg5", 32'hA5A5_A5A5);   got(bus.d_rs_data);
    step();
    drive(32'h3034, 32'h0, 32'h0, 32'h0, 32'h0, 5'd10, 5'd8);
    #1;
    want("lui_reg10", 32'hBEEF_0000); got(bus.d_rs_data);
    want("lui_retired", 32'd7);       got(bus.retired);
    step();

    // 6: lw $9 killed by an asynchronous reset before its edge
    drive(32'h3038, 32'h8C09_0000, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd9, 5'd8);
    #1;
    want("lw_wb_data", 32'hCAFE_F00D); got(bus.wb_data);
    want("lw_bypass9", 32'hCAFE_F00D); got(bus.d_rs_data);
    #2;
    reset = 1'b1;
    #1;
    want("async_retired", 32'h0); got(bus.retired);
    want("async_reg8", 32'h0);    got(bus.d_rt_data);
    step();
    reset = 1'b0;
    drive(32'h303c, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd31);
    #1;
    want("lw_lost_reg9", 32'h0);   got(bus.d_rs_data);
    want("rst_reg31", 32'h0);      got(bus.d_rt_data);
    want("post_rst_retired", 32'h0); got(bus.retired);

    if (exp_q.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_leftover: got %0d unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
